// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the 3-bit recoding function.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit 2 is the negate flag, bits 1:0 select 0 / 1x / 2x magnitude.
    typedef enum logic [2:0] {
        DIG_ZERO = 3'b000,
        DIG_POS1 = 3'b001,
        DIG_POS2 = 3'b010,
        DIG_NEG1 = 3'b101,
        DIG_NEG2 = 3'b110
    } booth_digit_t;

    function automatic booth_digit_t booth_encode(input logic [2:0] bits);
        booth_digit_t d;
        case (bits)
            3'b001, 3'b010: d = DIG_POS1;
            3'b011:         d = DIG_POS2;
            3'b100:         d = DIG_NEG2;
            3'b101, 3'b110: d = DIG_NEG1;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Combinational radix-4 Booth partial product: digit * a_ext, shifted left by
// two bits per digit index, all modulo 2^(2*WIDTH).
module booth_r4_pp_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [2*WIDTH-1:0] a_ext_i,
    input  logic [2:0]         bits_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [2*WIDTH-1:0] pp_o
);

    booth_digit_t       digit;
    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] term;

    always_comb begin
        digit = booth_encode(bits_i);
        mag   = '0;
        case (digit)
            DIG_POS1, DIG_NEG1: mag = a_ext_i;
            DIG_POS2, DIG_NEG2: mag = a_ext_i << 1;
            default:            mag = '0;
        endcase
        term = digit[2] ? (~mag + (2*WIDTH)'(1)) : mag;
        pp_o = term << {idx_i, 1'b0};
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Multi-cycle radix-4 Booth multiplier: sums PP_PER_CYCLE partial products per
// RUN cycle, then spends one final RUN cycle loading the product register.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               alu_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int NPP   = WIDTH / 2 + 1;
    localparam int NCYC  = (NPP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int CNT_W = $clog2(NCYC + 1);
    localparam int IDX_W = $clog2((NCYC + 1) * PP_PER_CYCLE + 1);
    localparam int PW    = 2 * WIDTH;
    localparam int PAD_W = 2 * (NCYC + 1) * PP_PER_CYCLE + 3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic             out_valid_q, out_valid_d;

    logic [PW-1:0]    a_ext;
    logic             b_msb;
    logic [PAD_W-1:0] b_pad;
    logic [PW-1:0]    pp [PP_PER_CYCLE];
    logic [PW-1:0]    pp_sum;
    logic             accept;

    assign a_ext = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};

    // Extension bits past digit NPP-1 are all copies of the sign (or zero), so
    // every digit index >= NPP recodes to 000/111 and contributes nothing.
    assign b_msb = signed_q & b_q[WIDTH-1];
    assign b_pad = {{(PAD_W-WIDTH-1){b_msb}}, b_q, 1'b0};

    for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_pp
        logic [IDX_W-1:0] idx;
        logic [2:0]       bits;

        assign idx  = IDX_W'(cnt_q) * IDX_W'(PP_PER_CYCLE) + IDX_W'(j);
        assign bits = 3'(b_pad >> {idx, 1'b0});

        booth_r4_pp_gen #(
            .WIDTH (WIDTH),
            .IDX_W (IDX_W)
        ) u_pp (
            .a_ext_i (a_ext),
            .bits_i  (bits),
            .idx_i   (idx),
            .pp_o    (pp[j])
        );
    end

    always_comb begin
        pp_sum = '0;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            pp_sum = pp_sum + pp[j];
        end
    end

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: ;
            RUN: begin
                if (cnt_q == CNT_W'(NCYC)) begin
                    product_d   = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d = acc_q + pp_sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept can only occur in IDLE or in DONE with the result consumed.
        if (accept) begin
            a_d      = a;
            b_d      = b;
            signed_d = alu_signed;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench: several multiplier instances of different WIDTH and
// PP_PER_CYCLE, a directed vector table, handshake/reset corner cases and random ops.
module tb_booth_r4_seq_mult;

    localparam int NI = 10;
    localparam int WS [NI] = '{8, 8, 8, 16, 16, 16, 32, 32, 32, 32};
    localparam int PS [NI] = '{1, 3, 5, 1,  3,  9,  1,  3,  17, 4};

    logic        clk;
    logic        rst_n;
    logic        in_valid   [NI];
    logic        in_ready   [NI];
    logic [31:0] a          [NI];
    logic [31:0] b          [NI];
    logic        alu_signed [NI];
    logic        out_valid  [NI];
    logic        out_ready  [NI];
    logic [63:0] product    [NI];
    logic        busy       [NI];

    int n_checks;
    int n_errors;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W-1:0]   a_w;
        logic [W-1:0]   b_w;
        logic [2*W-1:0] p_w;

        assign a_w        = a[g][W-1:0];
        assign b_w        = b[g][W-1:0];
        assign product[g] = 64'(p_w);

        booth_r4_seq_mult #(
            .WIDTH        (W),
            .PP_PER_CYCLE (PS[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .a          (a_w),
            .b          (b_w),
            .alu_signed (alu_signed[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .product    (p_w),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact product of the extended operands, reduced to 2*W bits.
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] lo_mask, ea, eb;
        lo_mask = (64'd1 << w) - 64'd1;
        ea = 64'(av) & lo_mask;
        eb = 64'(bv) & lo_mask;
        if (s && av[w-1]) ea = ea | ~lo_mask;
        if (s && bv[w-1]) eb = eb | ~lo_mask;
        return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    function automatic int exp_lat(input int k);
        int npp;
        npp = WS[k] / 2 + 1;
        return (npp + PS[k] - 1) / PS[k] + 1;
    endfunction

    // Called at the negedge after the accept edge; counts edges until out_valid.
    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 200) begin
            in_valid[k] = 1'($urandom_range(0, 1));
            a[k] = $urandom;
            @(negedge clk);
            lat++;
        end
        if (!out_valid[k]) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: instance %0d never raised out_valid", k);
        end
    endtask

    task automatic run_op(input int k, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, output logic [63:0] p, output int lat);
        @(negedge clk);
        in_valid[k]   = 1'b1;
        a[k]          = av;
        b[k]          = bv;
        alu_signed[k] = s;
        out_ready[k]  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[k]   = 1'b0;
        b[k]          = $urandom;
        alu_signed[k] = ~s;
        wait_valid(k, lat);
        p = product[k];
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    typedef struct {
        int          k;
        logic        s;
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vt [$];
    logic [63:0] p, p0;
    int          lat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]   = 1'b0;
            a[k]          = '0;
            b[k]          = '0;
            alu_signed[k] = 1'b0;
            out_ready[k]  = 1'b0;
        end
        rst_n = 1'b0;

        vt.push_back('{6, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1,                   18});
        vt.push_back('{6, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 18});
        vt.push_back('{9, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6});
        vt.push_back('{0, 1'b1, 32'h80,        32'h80,        64'h4000,                6});
        vt.push_back('{1, 1'b0, 32'hFF,        32'hFF,        64'hFE01,                3});
        vt.push_back('{2, 1'b1, 32'h80,        32'h7F,        64'hC080,                2});
        vt.push_back('{3, 1'b1, 32'h8000,      32'h8000,      64'h4000_0000,           10});
        vt.push_back('{4, 1'b0, 32'hFFFF,      32'hFFFF,      64'hFFFE_0001,           4});
        vt.push_back('{5, 1'b1, 32'h7FFF,      32'h8000,      64'hC000_8000,           2});
        vt.push_back('{7, 1'b0, 32'h8000_0000, 32'h2,         64'h1_0000_0000,         7});
        vt.push_back('{8, 1'b1, 32'd100000,    32'hFFFF_FF85, 64'hFFFF_FFFF_FF44_5120, 2});
        vt.push_back('{7, 1'b1, 32'h0,         32'h8000_0000, 64'h0,                   7});

        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset out_valid[%0d]", k), 64'(out_valid[k]), 64'h0);
            chk($sformatf("reset product[%0d]", k),   product[k],          64'h0);
            chk($sformatf("reset busy[%0d]", k),      64'(busy[k]),        64'h0);
            chk($sformatf("reset in_ready[%0d]", k),  64'(in_ready[k]),    64'h1);
        end
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].k, vt[i].s, vt[i].av, vt[i].bv, p, lat);
            chk($sformatf("vec%0d product", i), p, vt[i].exp);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vt[i].lat));
        end

        // Back-pressure in DONE, then release with a same-cycle accept.
        @(negedge clk);
        in_valid[6] = 1'b1; a[6] = 32'd7; b[6] = 32'd9; alu_signed[6] = 1'b0; out_ready[6] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[6] = 1'b0;
        wait_valid(6, lat);
        p0 = product[6];
        chk("hold first product", p0, 64'd63);
        for (int c = 0; c < 5; c++) begin
            in_valid[6] = 1'b1;
            a[6] = $urandom;
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", c), 64'(out_valid[6]), 64'h1);
            chk($sformatf("hold%0d product", c),   product[6],          p0);
            chk($sformatf("hold%0d in_ready", c),  64'(in_ready[6]),    64'h0);
        end
        in_valid[6] = 1'b1; a[6] = 32'd3; b[6] = 32'd5; alu_signed[6] = 1'b0; out_ready[6] = 1'b1;
        #1;
        chk("release in_ready", 64'(in_ready[6]), 64'h1);
        @(posedge clk);
        @(negedge clk);
        in_valid[6] = 1'b0; out_ready[6] = 1'b0;
        chk("release busy", 64'(busy[6]), 64'h1);
        chk("release out_valid", 64'(out_valid[6]), 64'h0);
        wait_valid(6, lat);
        in_valid[6] = 1'b0;
        chk("release product", product[6], 64'd15);
        chk("release latency", 64'(lat), 64'd18);
        out_ready[6] = 1'b1;
        @(negedge clk);
        out_ready[6] = 1'b0;

        // Abort mid-RUN.
        in_valid[6] = 1'b1; a[6] = 32'd5; b[6] = 32'd5; alu_signed[6] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[6] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort run out_valid", 64'(out_valid[6]), 64'h0);
        chk("abort run product",   product[6],          64'h0);
        chk("abort run in_ready",  64'(in_ready[6]),    64'h1);
        chk("abort run busy",      64'(busy[6]),        64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(6, 1'b1, 32'd100000, 32'hFFFF_FF85, p, lat);
        chk("post abort product", p, 64'hFFFF_FFFF_FF44_5120);

        // Abort while holding a result in DONE.
        @(negedge clk);
        in_valid[7] = 1'b1; a[7] = 32'd3; b[7] = 32'd3; alu_signed[7] = 1'b0; out_ready[7] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[7] = 1'b0;
        wait_valid(7, lat);
        in_valid[7] = 1'b0;
        chk("abort done product before", product[7], 64'd9);
        rst_n = 1'b0;
        #1;
        chk("abort done out_valid", 64'(out_valid[7]), 64'h0);
        chk("abort done product",   product[7],          64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            int          k;
            int          w;
            logic        s;
            logic [31:0] av, bv, m;
            k  = $urandom_range(0, NI - 1);
            w  = WS[k];
            s  = 1'($urandom_range(0, 1));
            m  = 32'((64'd1 << w) - 64'd1);
            av = $urandom & m;
            bv = $urandom & m;
            if ($urandom_range(0, 7) == 0) av = 32'(64'd1 << (w - 1));
            if ($urandom_range(0, 7) == 0) bv = m;
            run_op(k, s, av, bv, p, lat);
            chk($sformatf("rand%0d inst%0d s%0d %h*%h", i, k, s, av, bv), p, ref_mul(w, s, av, bv));
            chk($sformatf("rand%0d latency inst%0d", i, k), 64'(lat), 64'(exp_lat(k)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
